simt_mem_stage: RTL and testbench

SIMT_MEM_STAGE -- requirements
Module: simt_mem_stage

---
 rtl/pkg_opengpu.sv | 23 ++
 rtl/simt_mem_stage_if.sv | 24 ++
 rtl/simt_mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_simt_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_opengpu.sv
// Shared OpenGPU widths and the decoded-instruction format passed between
// pipeline stages.
package pkg_opengpu;

    localparam int WARP_SIZE  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } decoded_instr_t;

    typedef struct packed {
        decoded_instr_t         base;
        logic [WARP_SIZE-1:0]   active_mask;
        logic [4:0]             warp_id;
    } simt_decoded_instr_t;

endpackage

// File: rtl/simt_mem_stage_if.sv
// Single-outstanding memory port used by the SIMT memory stage: one request
// handshake (req/ready) plus an in-order load response channel.
interface simt_mem_stage_if #(
    parameter int ADDR_WIDTH = pkg_opengpu::ADDR_WIDTH,
    parameter int DATA_WIDTH = pkg_opengpu::DATA_WIDTH
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/simt_mem_stage.sv
// SIMT memory stage: serialises the active lanes of a warp memory instruction
// into single memory requests and gathers load data into a per-lane result.
module simt_mem_stage #(
    parameter int WARP_SIZE  = pkg_opengpu::WARP_SIZE,
    parameter int DATA_WIDTH = pkg_opengpu::DATA_WIDTH,
    parameter int ADDR_WIDTH = pkg_opengpu::ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 stall,
    input  logic                                 flush,
    input  pkg_opengpu::simt_decoded_instr_t     decoded_in,
    input  logic [ADDR_WIDTH-1:0]                pc_in,
    input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] alu_result,
    input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] store_data,
    input  logic                                 valid_in,
    output logic                                 busy,
    simt_mem_stage_if.master                     mem,
    output pkg_opengpu::simt_decoded_instr_t     decoded_out,
    output logic [ADDR_WIDTH-1:0]                pc_out,
    output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] result,
    output logic                                 valid_out
);
    localparam int LANE_W = (WARP_SIZE > 1) ? $clog2(WARP_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DRAIN} state_t;

    state_t                               state, state_nxt;
    logic [LANE_W-1:0]                    lane, lane_nxt;
    logic [WARP_SIZE-1:0]                 pending, pending_nxt, pending_after, lane_bit;
    logic                                 done, done_nxt;
    pkg_opengpu::simt_decoded_instr_t     instr_q;
    logic [ADDR_WIDTH-1:0]                pc_q;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] addr_q, wdata_q, buf_q, buf_nxt;
    logic accept, out_blocked, is_mem_in, issuing, handshake, rsp_hit, step, last_lane;
    logic capture, load_alu, load_mem;

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [WARP_SIZE-1:0] m);
        lowest_lane = '0;
        for (int i = WARP_SIZE - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

    assign out_blocked = valid_out && stall;
    assign busy        = (state != IDLE) || out_blocked;
    assign accept      = valid_in && !busy && !flush;
    assign is_mem_in   = decoded_in.base.mem_read || decoded_in.base.mem_write;

    // 'done' marks a finished instruction waiting for the output register.
    assign issuing   = (state == ISSUE) && !done;
    assign handshake = issuing && mem.mem_ready;
    assign rsp_hit   = (state == WAIT_RSP) && !done && mem.mem_rsp_valid;
    assign step      = (handshake && instr_q.base.mem_write) || rsp_hit;

    assign mem.mem_req   = issuing;
    assign mem.mem_we    = issuing && instr_q.base.mem_write;
    assign mem.mem_addr  = issuing ? addr_q[lane][ADDR_WIDTH-1:0] : '0;
    assign mem.mem_wdata = issuing ? wdata_q[lane] : '0;

    always_comb begin
        lane_bit       = '0;
        lane_bit[lane] = 1'b1;
        pending_after  = pending & ~lane_bit;
        last_lane      = (pending_after == '0);
        buf_nxt        = buf_q;
        if (rsp_hit) buf_nxt[lane] = mem.mem_rsp_data;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        lane_nxt    = lane;
        pending_nxt = pending;
        done_nxt    = done;
        capture     = 1'b0;
        load_alu    = 1'b0;
        load_mem    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem_in && (decoded_in.active_mask != '0)) begin
                        capture     = 1'b1;
                        state_nxt   = ISSUE;
                        pending_nxt = decoded_in.active_mask;
                        lane_nxt    = lowest_lane(decoded_in.active_mask);
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_nxt = (handshake && !instr_q.base.mem_write) ? DRAIN : IDLE;
                    done_nxt  = 1'b0;
                end else if (handshake && !instr_q.base.mem_write) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (flush) begin
                    state_nxt = (rsp_hit || done) ? IDLE : DRAIN;
                    done_nxt  = 1'b0;
                end
            end
            DRAIN: begin
                if (mem.mem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Lane retirement and completion are shared by the ISSUE and WAIT_RSP paths.
        if (!flush && ((state == ISSUE) || (state == WAIT_RSP))) begin
            if (step) begin
                pending_nxt = pending_after;
                if (!last_lane) begin
                    lane_nxt  = lowest_lane(pending_after);
                    state_nxt = ISSUE;
                end
            end
            if (done || (step && last_lane)) begin
                if (out_blocked) begin
                    done_nxt = 1'b1;
                end else begin
                    load_mem  = 1'b1;
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lane    <= '0;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            lane    <= lane_nxt;
            pending <= pending_nxt;
            done    <= done_nxt;
        end
    end

    // NOTE: the latched warp data is not reset; it is only observed through
    // state-qualified outputs and the buffer is cleared when an instruction is captured.
    always_ff @(posedge clk) begin
        if (capture) begin
            instr_q <= decoded_in;
            pc_q    <= pc_in;
            addr_q  <= alu_result;
            wdata_q <= store_data;
            buf_q   <= '0;
        end else begin
            buf_q   <= buf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            decoded_out <= '0;
            pc_out      <= '0;
            result      <= '0;
        end else if (load_alu) begin
            valid_out   <= 1'b1;
            decoded_out <= decoded_in;
            pc_out      <= pc_in;
            result      <= alu_result;
        end else if (load_mem) begin
            valid_out   <= 1'b1;
            decoded_out <= instr_q;
            pc_out      <= pc_q;
            result      <= buf_nxt;
        end else if (flush || !stall) begin
            valid_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simt_mem_stage.sv
// Directed bench for simt_mem_stage: a vector table for single-cycle
// instructions plus scripted sequences for lane serialisation, flush and stall.
module tb_simt_mem_stage;
    import pkg_opengpu::*;

    localparam int W  = WARP_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst_n, stall, flush, valid_in, busy, valid_out;
    simt_decoded_instr_t       decoded_in, decoded_out;
    logic [AW-1:0]             pc_in, pc_out;
    logic [W-1:0][DW-1:0]      alu_result, store_data, result;

    simt_mem_stage_if mem_if ();

    simt_mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .decoded_in  (decoded_in),
        .pc_in       (pc_in),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .valid_in    (valid_in),
        .busy        (busy),
        .mem         (mem_if),
        .decoded_out (decoded_out),
        .pc_out      (pc_out),
        .result      (result),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mask;
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] pc;
        logic [31:0] exp_l0;
        logic [31:0] exp_l31;
    } vec_t;

    vec_t vecs [4];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] req_addr_q [$];
    logic [31:0] req_wdata_q [$];
    logic        req_we_q [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_res(input string name, input logic [W-1:0][DW-1:0] exp);
        int bad;
        bad = -1;
        n_checks++;
        for (int i = W - 1; i >= 0; i--) if (result[i] !== exp[i]) bad = i;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: lane %0d got 0x%0h expected 0x%0h", name, bad, result[bad], exp[bad]);
    endtask

    function automatic simt_decoded_instr_t mk(input logic rd, input logic wr,
                                               input logic [W-1:0] mask, input logic [5:0] op);
        simt_decoded_instr_t d;
        d                = '0;
        d.base.opcode    = op;
        d.base.mem_read  = rd;
        d.base.mem_write = wr;
        d.base.reg_write = !wr;
        d.active_mask    = mask;
        return d;
    endfunction

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [31:0] q_addr(input int i);
        return (req_addr_q.size() > i) ? req_addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_wdata(input int i);
        return (req_wdata_q.size() > i) ? req_wdata_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic q_we(input int i);
        return (req_we_q.size() > i) ? req_we_q[i] : 1'bx;
    endfunction

    // Memory model: ready after ready_wait cycles of a pending request, load data
    // rsp_lat cycles after the handshake; runs until valid_out or a cycle budget.
    task automatic service(input int ready_wait, input int rsp_lat, output int cycles);
        int          wait_cnt, rsp_cnt;
        logic        held;
        logic [31:0] pend_addr, held_addr, held_wdata;
        wait_cnt = 0; rsp_cnt = -1; held = 1'b0; cycles = 0;
        pend_addr = '0; held_addr = '0; held_wdata = '0;
        req_addr_q.delete(); req_wdata_q.delete(); req_we_q.delete();
        while (!valid_out && cycles < 200) begin
            mem_if.mem_rsp_valid = (rsp_cnt == 0);
            mem_if.mem_rsp_data  = (rsp_cnt == 0) ? rsp_of(pend_addr) : 32'h0;
            mem_if.mem_ready     = mem_if.mem_req && (wait_cnt >= ready_wait);
            if (mem_if.mem_req && held) begin
                check("req_addr_stable", 64'(mem_if.mem_addr), 64'(held_addr));
                check("req_wdata_stable", 64'(mem_if.mem_wdata), 64'(held_wdata));
            end
            if (mem_if.mem_req && mem_if.mem_ready) begin
                req_addr_q.push_back(mem_if.mem_addr);
                req_wdata_q.push_back(mem_if.mem_wdata);
                req_we_q.push_back(mem_if.mem_we);
                if (!mem_if.mem_we) begin
                    pend_addr = mem_if.mem_addr;
                    rsp_cnt   = rsp_lat;
                end
                held = 1'b0; wait_cnt = 0;
            end else if (mem_if.mem_req) begin
                held = 1'b1; held_addr = mem_if.mem_addr; held_wdata = mem_if.mem_wdata;
                wait_cnt++;
            end else begin
                held = 1'b0;
            end
            tick;
            cycles++;
            if (rsp_cnt >= 0) rsp_cnt--;
        end
        mem_if.mem_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0;
        check("service_finished", 64'(valid_out), 64'd1);
    endtask

    logic [W-1:0][DW-1:0] zv, ev;
    int cyc;

    initial begin
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        decoded_in = '0; pc_in = '0; alu_result = '0; store_data = '0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_data = '0;
        zv = '0;
        //           rd    wr    mask          base          stride     pc           lane0         lane31
        vecs[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h1,    32'h10, 32'h0,        32'd31};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_FFFF, 32'h1000,     32'h4,    32'h14, 32'h1000,     32'h107C};
        vecs[2] = '{1'b1, 1'b0, 32'h0,         32'hDEAD_0000, 32'h10,  32'h18, 32'hDEAD_0000, 32'hDEAD_01F0};
        vecs[3] = '{1'b0, 1'b1, 32'h0,         32'hFFFF_FFF0, 32'h1,   32'h1C, 32'hFFFF_FFF0, 32'h0000_000F};

        #1 rst_n = 1'b0;
        #1;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_if.mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_if.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_if.mem_wdata), 64'd0);
        check("rst_pc_out", 64'(pc_out), 64'd0);
        check("rst_decoded_out", 64'(decoded_out), 64'd0);
        check_res("rst_result", zv);
        tick; tick;
        rst_n = 1'b1;
        tick;
        check("idle_busy", 64'(busy), 64'd0);

        // Single-cycle instructions: ALU ops and zero-mask memory ops.
        for (int v = 0; v < 4; v++) begin
            decoded_in = mk(vecs[v].mem_read, vecs[v].mem_write, vecs[v].mask, 6'(v + 1));
            pc_in      = vecs[v].pc;
            for (int i = 0; i < W; i++) begin
                alu_result[i] = vecs[v].base + 32'(i) * vecs[v].stride;
                store_data[i] = ~alu_result[i];
            end
            valid_in = 1'b1;
            check($sformatf("v%0d_busy_before", v), 64'(busy), 64'd0);
            tick;
            valid_in = 1'b0;
            check($sformatf("v%0d_valid_out", v), 64'(valid_out), 64'd1);
            check($sformatf("v%0d_mem_req", v), 64'(mem_if.mem_req), 64'd0);
            check($sformatf("v%0d_pc_out", v), 64'(pc_out), 64'(vecs[v].pc));
            check($sformatf("v%0d_lane0", v), 64'(result[0]), 64'(vecs[v].exp_l0));
            check($sformatf("v%0d_lane31", v), 64'(result[31]), 64'(vecs[v].exp_l31));
            check_res($sformatf("v%0d_result", v), alu_result);
            tick;
            check($sformatf("v%0d_valid_clear", v), 64'(valid_out), 64'd0);
        end

        // Sparse-mask load: lanes 0 and 2 only, response two cycles after each request.
        alu_result = '0; store_data = '0;
        alu_result[0] = 32'h100; alu_result[1] = 32'h104; alu_result[2] = 32'h108;
        decoded_in = mk(1'b1, 1'b0, 32'h5, 6'h23);
        pc_in = 32'h2000;
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        check("ld_busy", 64'(busy), 64'd1);
        service(0, 2, cyc);
        check("ld_cycles", 64'(cyc), 64'd6);
        check("ld_req_count", 64'(req_addr_q.size()), 64'd2);
        check("ld_addr0", 64'(q_addr(0)), 64'h100);
        check("ld_addr1", 64'(q_addr(1)), 64'h108);
        check("ld_we0", 64'(q_we(0)), 64'd0);
        check("ld_pc_out", 64'(pc_out), 64'h2000);
        ev = '0; ev[0] = 32'hCAFE_0100; ev[2] = 32'hCAFE_0108;
        check_res("ld_result", ev);
        check("ld_busy_after", 64'(busy), 64'd0);
        tick;

        // Two-lane store with three wait cycles per request.
        alu_result = '0; store_data = '0;
        alu_result[0] = 32'h200; alu_result[1] = 32'h204;
        store_data[0] = 32'h5000; store_data[1] = 32'h5001;
        decoded_in = mk(1'b0, 1'b1, 32'h3, 6'h2B);
        pc_in = 32'h3000;
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        service(3, 1, cyc);
        check("st_cycles", 64'(cyc), 64'd8);
        check("st_req_count", 64'(req_addr_q.size()), 64'd2);
        check("st_addr0", 64'(q_addr(0)), 64'h200);
        check("st_wdata0", 64'(q_wdata(0)), 64'h5000);
        check("st_we0", 64'(q_we(0)), 64'd1);
        check("st_addr1", 64'(q_addr(1)), 64'h204);
        check("st_wdata1", 64'(q_wdata(1)), 64'h5001);
        check("st_decoded_we", 64'(decoded_out.base.mem_write), 64'd1);
        check_res("st_result_zero", zv);
        tick;

        // Flush while a request is pending in ISSUE.
        alu_result = '0; alu_result[0] = 32'h300;
        decoded_in = mk(1'b1, 1'b0, 32'h1, 6'h23);
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        check("fi_mem_req", 64'(mem_if.mem_req), 64'd1);
        check("fi_mem_addr", 64'(mem_if.mem_addr), 64'h300);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fi_mem_req_after", 64'(mem_if.mem_req), 64'd0);
        check("fi_busy_after", 64'(busy), 64'd0);
        check("fi_valid_out", 64'(valid_out), 64'd0);

        // Flush in WAIT_RSP: DRAIN holds busy until the orphan response arrives.
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        mem_if.mem_ready = 1'b1;
        tick;
        mem_if.mem_ready = 1'b0;
        check("fw_wait_mem_req", 64'(mem_if.mem_req), 64'd0);
        check("fw_wait_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fw_drain_busy", 64'(busy), 64'd1);
        check("fw_drain_valid", 64'(valid_out), 64'd0);
        tick;
        check("fw_drain_holds", 64'(busy), 64'd1);
        mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'h1234_5678;
        tick;
        mem_if.mem_rsp_valid = 1'b0;
        check("fw_idle_busy", 64'(busy), 64'd0);
        check("fw_idle_valid", 64'(valid_out), 64'd0);

        // Stall holds the output register and blocks new work; flush still clears it.
        alu_result = '0;
        for (int i = 0; i < W; i++) alu_result[i] = 32'hA0 + 32'(i);
        decoded_in = mk(1'b0, 1'b0, '1, 6'h01);
        pc_in = 32'h40;
        valid_in = 1'b1;
        tick;
        stall = 1'b1;
        decoded_in = mk(1'b1, 1'b0, 32'h2, 6'h23);
        pc_in = 32'h80;
        tick; tick; tick;
        check("sh_busy", 64'(busy), 64'd1);
        check("sh_valid", 64'(valid_out), 64'd1);
        check("sh_pc_hold", 64'(pc_out), 64'h40);
        check("sh_lane0_hold", 64'(result[0]), 64'hA0);
        check("sh_no_req", 64'(mem_if.mem_req), 64'd0);
        valid_in = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("sh_flush_clears", 64'(valid_out), 64'd0);

        // Load completing under stall with an empty output register, then held.
        alu_result = '0; alu_result[1] = 32'h404;
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        service(0, 1, cyc);
        check("sl_cycles", 64'(cyc), 64'd2);
        check("sl_addr", 64'(q_addr(0)), 64'h404);
        tick; tick;
        check("sl_valid_hold", 64'(valid_out), 64'd1);
        check("sl_pc_hold", 64'(pc_out), 64'h80);
        ev = '0; ev[1] = 32'hCAFE_0404;
        check_res("sl_result", ev);
        stall = 1'b0;
        tick;
        check("sl_valid_clear", 64'(valid_out), 64'd0);

        // Reset mid-transaction drops the outstanding request immediately.
        alu_result = '0; alu_result[0] = 32'h500;
        decoded_in = mk(1'b1, 1'b0, 32'h1, 6'h23);
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        check("mr_req_before", 64'(mem_if.mem_req), 64'd1);
        rst_n = 1'b0;
        #2;
        check("mr_req_in_reset", 64'(mem_if.mem_req), 64'd0);
        check("mr_busy_in_reset", 64'(busy), 64'd0);
        rst_n = 1'b1;
        mem_if.mem_rsp_valid = 1'b1;
        tick;
        mem_if.mem_rsp_valid = 1'b0;
        check("mr_idle_after", 64'(busy), 64'd0);
        check("mr_valid_after", 64'(valid_out), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
